// File: rtl/fir_mac_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_scheduler_if
// Brief    : Bundle of the sample handshake, sample-RAM / coefficient-ROM
//            address buses, MAC control/result and filter output signals.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_scheduler_if #(
  parameter int SAMP_AW   = 3,
  parameter int COEF_AW   = 5,
  parameter int WIDTH_OUT = 40,
  parameter int PHASE_W   = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        samp_we;
  logic [SAMP_AW-1:0]          samp_wr_addr;
  logic [SAMP_AW-1:0]          samp_rd_addr;
  logic [COEF_AW-1:0]          coef_rd_addr;
  logic                        mac_accum_sload;
  logic signed [WIDTH_OUT-1:0] mac_result;
  logic                        out_valid;
  logic signed [WIDTH_OUT-1:0] out_data;
  logic [PHASE_W-1:0]          out_phase;
  logic                        busy;

  // Scheduler side
  modport master (
    input  in_valid,
    output in_ready,
    output samp_we,
    output samp_wr_addr,
    output samp_rd_addr,
    output coef_rd_addr,
    output mac_accum_sload,
    input  mac_result,
    output out_valid,
    output out_data,
    output out_phase,
    output busy
  );

  // Environment side: upstream source, memories, MAC and output sink
  modport slave (
    output in_valid,
    input  in_ready,
    input  samp_we,
    input  samp_wr_addr,
    input  samp_rd_addr,
    input  coef_rd_addr,
    input  mac_accum_sload,
    output mac_result,
    input  out_valid,
    input  out_data,
    input  out_phase,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_scheduler
// Brief    : Polyphase FIR tap scheduler. Stores one sample per request into
//            an external ring RAM, then for every phase issues one tap per
//            cycle to an external 3-stage MAC and captures the phase output.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_scheduler #(
  parameter int TAPS_PER_PHASE = 8,
  parameter int NUM_PHASES     = 4,
  parameter int SAMP_AW        = 3,
  parameter int COEF_AW        = 5,
  parameter int WIDTH_OUT      = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_mac_scheduler_if.master bus
);

  localparam int c_PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int c_K_W  = $clog2(TAPS_PER_PHASE);

  localparam logic [c_K_W-1:0]  c_K_LAST     = c_K_W'(TAPS_PER_PHASE - 1);
  localparam logic [c_PH_W-1:0] c_PH_LAST    = c_PH_W'(NUM_PHASES - 1);
  // Three drain cycles: RAM/ROM read, operand->product stage, result register
  localparam logic [1:0]        c_DRAIN_LAST = 2'd2;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_WRITE = 3'd1;
  localparam logic [2:0] c_ISSUE = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_EMIT  = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [SAMP_AW-1:0]   r_wr_ptr;
  logic [c_PH_W-1:0]    r_phase;
  logic [c_K_W-1:0]     r_k;
  logic [1:0]           r_drain;
  logic                 r_sload_d;
  logic                 r_sload;
  logic                 r_out_valid;
  logic [WIDTH_OUT-1:0] r_out_data;
  logic [c_PH_W-1:0]    r_out_phase;

  logic                 w_in_ready;
  logic                 w_tap0;
  logic [SAMP_AW-1:0]   w_samp_rd_addr;
  logic [COEF_AW-1:0]   w_coef_rd_addr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (bus.in_valid) w_state_nxt = c_WRITE;
      c_WRITE: w_state_nxt = c_ISSUE;
      c_ISSUE: if (r_k == c_K_LAST) w_state_nxt = c_DRAIN;
      c_DRAIN: if (r_drain == c_DRAIN_LAST) w_state_nxt = c_EMIT;
      c_EMIT:  w_state_nxt = (r_phase == c_PH_LAST) ? c_IDLE : c_ISSUE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Handshake and tap address decode; read addresses idle at zero outside ISSUE
  always_comb begin
    w_in_ready     = rst_n && (r_state == c_IDLE);
    w_tap0         = (r_state == c_ISSUE) && (r_k == '0);
    w_samp_rd_addr = '0;
    w_coef_rd_addr = '0;
    if (r_state == c_ISSUE) begin
      // Tap 0 is the newest sample, one slot behind the write pointer
      w_samp_rd_addr = r_wr_ptr - SAMP_AW'(1) - SAMP_AW'(r_k);
      w_coef_rd_addr = COEF_AW'(r_phase) * COEF_AW'(TAPS_PER_PHASE) + COEF_AW'(r_k);
    end
  end

  // Write pointer, phase, tap and drain counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_phase  <= '0;
      r_k      <= '0;
      r_drain  <= '0;
    end else begin
      case (r_state)
        c_WRITE: begin
          r_wr_ptr <= r_wr_ptr + SAMP_AW'(1);
          r_phase  <= '0;
          r_k      <= '0;
        end
        c_ISSUE: begin
          r_drain <= '0;
          if (r_k != c_K_LAST) r_k <= r_k + c_K_W'(1);
        end
        c_DRAIN: r_drain <= r_drain + 2'd1;
        c_EMIT: begin
          if (r_phase != c_PH_LAST) begin
            r_phase <= r_phase + c_PH_W'(1);
            r_k     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: sload lands two cycles after tap 0, result captured in EMIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sload_d   <= 1'b0;
      r_sload     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_phase <= '0;
    end else begin
      r_sload_d   <= w_tap0;
      r_sload     <= r_sload_d;
      r_out_valid <= (r_state == c_EMIT);
      if (r_state == c_EMIT) begin
        r_out_data  <= bus.mac_result;
        r_out_phase <= r_phase;
      end
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.samp_we         = w_in_ready && bus.in_valid;
  assign bus.samp_wr_addr    = r_wr_ptr;
  assign bus.samp_rd_addr    = w_samp_rd_addr;
  assign bus.coef_rd_addr    = w_coef_rd_addr;
  assign bus.mac_accum_sload = r_sload;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_data        = r_out_data;
  assign bus.out_phase       = r_out_phase;
  assign bus.busy            = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_scheduler
// Brief    : Testbench for fir_mac_scheduler with sample RAM, coefficient ROM
//            and 3-stage MAC models, plus a dot-product reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_scheduler;

  localparam int T     = 8;
  localparam int P     = 4;
  localparam int SAW   = 3;
  localparam int CAW   = 5;
  localparam int WO    = 40;
  localparam int PW    = 2;
  localparam int DEPTH = 1 << SAW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_mac_scheduler_if #(.SAMP_AW(SAW), .COEF_AW(CAW), .WIDTH_OUT(WO), .PHASE_W(PW)) bus ();

  fir_mac_scheduler #(
    .TAPS_PER_PHASE(T), .NUM_PHASES(P), .SAMP_AW(SAW), .COEF_AW(CAW), .WIDTH_OUT(WO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // External memories and MAC
  logic                 ram_clr;
  logic signed [15:0]   in_data;
  logic signed [15:0]   ram [DEPTH];
  logic signed [15:0]   rom [T*P];
  logic signed [15:0]   ram_q, rom_q, op_a, op_b;
  logic signed [WO-1:0] prod, acc;
  logic                 sl1;

  assign bus.mac_result = acc;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Ring RAM and ROM with one-cycle read, MAC: operands -> product -> accumulator
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (bus.samp_we) begin
      ram[bus.samp_wr_addr] <= in_data;
    end
    ram_q <= ram[bus.samp_rd_addr];
    rom_q <= rom[bus.coef_rd_addr];
    op_a  <= ram_q;
    op_b  <= rom_q;
    prod  <= WO'(op_a) * WO'(op_b);
    sl1   <= bus.mac_accum_sload;
    acc   <= sl1 ? prod : acc + prod;
  end

  // Event monitor
  int                   o_cyc[$], o_ph[$], sl_cyc[$], wr_cyc[$], wr_adr[$];
  logic signed [WO-1:0] o_dat[$];
  int                   ir_bad = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        o_cyc.push_back(cyc);
        o_ph.push_back(int'(bus.out_phase));
        o_dat.push_back(bus.out_data);
      end
      if (bus.mac_accum_sload) sl_cyc.push_back(cyc);
      if (bus.samp_we) begin
        wr_cyc.push_back(cyc);
        wr_adr.push_back(int'(bus.samp_wr_addr));
      end
      if (bus.in_ready !== !bus.busy) ir_bad++;
    end
  end

  // Reference model: coefficient table and ring contents indexed by the model's own pointer
  logic signed [15:0] coef [T*P];
  logic signed [15:0] ring [DEPTH];
  int                 wp;

  function automatic logic signed [WO-1:0] expect_out(input int p);
    logic signed [WO-1:0] s;
    s = '0;
    for (int k = 0; k < T; k++)
      s = s + WO'(coef[p*T+k]) * WO'(ring[(wp - 1 - k) & (DEPTH - 1)]);
    return s;
  endfunction

  task automatic load_coefs(input int mode);
    for (int i = 0; i < T*P; i++) begin
      logic signed [15:0] c;
      c = (mode == 0) ? 16'($urandom) : (mode == 1) ? 16'sd1 : 16'(i);
      coef[i] = c;
      rom[i]  = c;
    end
  endtask

  task automatic clear_mon();
    o_cyc.delete(); o_ph.delete(); o_dat.delete();
    sl_cyc.delete(); wr_cyc.delete(); wr_adr.delete();
  endtask

  task automatic send_sample(input logic signed [15:0] d, output int a);
    int n;
    n = 0;
    a = -1;
    in_data = d;
    bus.in_valid = 1'b1;
    while (a < 0 && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) a = cyc;
      n++;
    end
    n_total++;
    if (a < 0) begin
      $display("FAIL accept_timeout got=no_accept exp=accept_within_200");
    end else begin
      n_pass++;
      ring[wp] = d;
      wp = (wp + 1) % DEPTH;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_burst(input int n_out);
    int n;
    n = 0;
    while ((o_cyc.size() < n_out || !bus.in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n >= 300) $display("FAIL burst_timeout got=%0d outputs exp=%0d", o_cyc.size(), n_out);
    else n_pass++;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ram_clr = 1'b0;
    wp = 0;
    @(negedge clk);
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== '0) $display("FAIL rst_out_data got=%0d exp=0", bus.out_data); else n_pass++;
    n_total++; if (bus.out_phase !== '0) $display("FAIL rst_out_phase got=%0d exp=0", bus.out_phase); else n_pass++;
    n_total++; if (bus.samp_we !== 1'b0) $display("FAIL rst_samp_we got=%0b exp=0", bus.samp_we); else n_pass++;
    n_total++; if (bus.mac_accum_sload !== 1'b0) $display("FAIL rst_sload got=%0b exp=0", bus.mac_accum_sload); else n_pass++;
    n_total++; if (bus.samp_rd_addr !== '0) $display("FAIL rst_samp_rd_addr got=%0d exp=0", bus.samp_rd_addr); else n_pass++;
    n_total++; if (bus.coef_rd_addr !== '0) $display("FAIL rst_coef_rd_addr got=%0d exp=0", bus.coef_rd_addr); else n_pass++;
    @(posedge clk); #1;
  endtask

  // One sample after reset: write address, output order, latency and spacing
  task automatic test_single();
    int a;
    logic signed [WO-1:0] e [P];
    load_coefs(0);
    clear_mon();
    send_sample(16'($urandom), a);
    for (int p = 0; p < P; p++) e[p] = expect_out(p);
    wait_burst(P);
    n_total++;
    if (wr_cyc.size() != 1 || wr_adr[0] != 0 || wr_cyc[0] != a)
      $display("FAIL single_write got(n=%0d addr=%0d) exp(n=1 addr=0)", wr_cyc.size(), wr_adr[0]);
    else n_pass++;
    n_total++;
    if (o_cyc.size() != P) $display("FAIL single_count got=%0d exp=%0d", o_cyc.size(), P); else n_pass++;
    for (int p = 0; p < P; p++) begin
      n_total++;
      if (o_cyc.size() <= p || o_ph[p] != p || o_cyc[p] != a + 14 + 12*p || o_dat[p] !== e[p])
        $display("FAIL single_out p=%0d got(cyc=%0d ph=%0d dat=%0d) exp(cyc=%0d ph=%0d dat=%0d)",
                 p, o_cyc[p] - a, o_ph[p], o_dat[p], 14 + 12*p, p, e[p]);
      else n_pass++;
    end
  endtask

  // All-ones coefficients, samples 1..9: ninth sample sums 9..2 across the wrapped ring
  task automatic test_ring_wrap();
    int a;
    load_coefs(1);
    for (int s = 1; s <= 9; s++) begin
      clear_mon();
      send_sample(16'(s), a);
      wait_burst(P);
    end
    for (int p = 0; p < P; p++) begin
      n_total++;
      if (o_dat.size() <= p || o_ph[p] != p || o_dat[p] !== WO'(44))
        $display("FAIL ring_wrap p=%0d got(ph=%0d dat=%0d) exp(ph=%0d dat=44)", p, o_ph[p], o_dat[p], p);
      else n_pass++;
    end
  endtask

  // Impulse through coef[i]=i: sample j after the impulse yields p*8+j on phase p
  task automatic test_impulse();
    int a;
    load_coefs(2);
    for (int s = 0; s < DEPTH; s++) begin
      clear_mon();
      send_sample(16'sd0, a);
      wait_burst(P);
    end
    for (int j = 0; j < T; j++) begin
      clear_mon();
      send_sample((j == 0) ? 16'sd1 : 16'sd0, a);
      wait_burst(P);
      for (int p = 0; p < P; p++) begin
        n_total++;
        if (o_dat.size() <= p || o_dat[p] !== WO'(p*T + j))
          $display("FAIL impulse j=%0d p=%0d got=%0d exp=%0d", j, p, o_dat[p], p*T + j);
        else n_pass++;
      end
    end
  endtask

  // in_valid held high across three samples
  task automatic test_back_to_back();
    int acc_n, n;
    int acc_c[$];
    logic signed [WO-1:0] e[$];
    acc_n = 0;
    n = 0;
    load_coefs(0);
    clear_mon();
    in_data = 16'($urandom);
    bus.in_valid = 1'b1;
    while (acc_n < 3 && n < 400) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc_c.push_back(cyc);
        ring[wp] = in_data;
        wp = (wp + 1) % DEPTH;
        for (int p = 0; p < P; p++) e.push_back(expect_out(p));
        acc_n++;
        @(posedge clk); #1;
        in_data = 16'($urandom);
      end else begin
        @(posedge clk); #1;
      end
      if (acc_n == 3) bus.in_valid = 1'b0;
      n++;
    end
    bus.in_valid = 1'b0;
    n_total++;
    if (acc_n != 3) $display("FAIL b2b_accepts got=%0d exp=3", acc_n); else n_pass++;
    wait_burst(3*P);
    n_total++;
    if (wr_cyc.size() != 3) $display("FAIL b2b_writes got=%0d exp=3", wr_cyc.size()); else n_pass++;
    for (int i = 1; i < 3; i++) begin
      n_total++;
      if (acc_c.size() <= i || acc_c[i] - acc_c[i-1] != 50)
        $display("FAIL b2b_gap i=%0d got=%0d exp=50", i, acc_c[i] - acc_c[i-1]);
      else n_pass++;
    end
    n_total++;
    if (o_cyc.size() != 3*P) $display("FAIL b2b_count got=%0d exp=%0d", o_cyc.size(), 3*P); else n_pass++;
    for (int i = 0; i < 3*P; i++) begin
      n_total++;
      if (o_dat.size() <= i || o_ph[i] != i % P || o_dat[i] !== e[i])
        $display("FAIL b2b_out i=%0d got(ph=%0d dat=%0d) exp(ph=%0d dat=%0d)", i, o_ph[i], o_dat[i], i % P, e[i]);
      else n_pass++;
    end
    n_total++;
    if (ir_bad != 0) $display("FAIL in_ready_vs_busy got=%0d bad_cycles exp=0", ir_bad); else n_pass++;
  endtask

  // Reset during phase 2 ISSUE, then a clean restart from address 0
  task automatic test_reset_mid();
    int a;
    load_coefs(0);
    clear_mon();
    send_sample(16'($urandom), a);
    while (cyc < a + 28) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wp = 0;
    repeat (40) @(negedge clk);
    n_total++;
    if (o_cyc.size() != 2) $display("FAIL rstmid_outputs got=%0d exp=2", o_cyc.size()); else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got=%0b exp=0", bus.busy); else n_pass++;
    @(posedge clk); #1;
    clear_mon();
    send_sample(16'($urandom), a);
    begin
      logic signed [WO-1:0] e [P];
      for (int p = 0; p < P; p++) e[p] = expect_out(p);
      wait_burst(P);
      n_total++;
      if (wr_adr.size() != 1 || wr_adr[0] != 0)
        $display("FAIL rstmid_waddr got(n=%0d addr=%0d) exp(n=1 addr=0)", wr_adr.size(), wr_adr[0]);
      else n_pass++;
      for (int p = 0; p < P; p++) begin
        n_total++;
        if (o_dat.size() <= p || o_ph[p] != p || o_cyc[p] != a + 14 + 12*p || o_dat[p] !== e[p])
          $display("FAIL rstmid_out p=%0d got(ph=%0d dat=%0d) exp(ph=%0d dat=%0d)", p, o_ph[p], o_dat[p], p, e[p]);
        else n_pass++;
      end
    end
  endtask

  // Random samples: sload count and placement, plus output values
  task automatic test_sload_stream();
    int a;
    logic signed [WO-1:0] e [P];
    load_coefs(0);
    for (int s = 0; s < 6; s++) begin
      clear_mon();
      send_sample(16'($urandom), a);
      for (int p = 0; p < P; p++) e[p] = expect_out(p);
      wait_burst(P);
      n_total++;
      if (sl_cyc.size() != P) $display("FAIL sload_count s=%0d got=%0d exp=%0d", s, sl_cyc.size(), P); else n_pass++;
      for (int p = 0; p < P; p++) begin
        n_total++;
        if (sl_cyc.size() <= p || sl_cyc[p] != a + 4 + 12*p)
          $display("FAIL sload_cycle s=%0d p=%0d got=%0d exp=%0d", s, p, sl_cyc[p] - a, 4 + 12*p);
        else n_pass++;
        n_total++;
        if (o_dat.size() <= p || o_ph[p] != p || o_dat[p] !== e[p])
          $display("FAIL stream_out s=%0d p=%0d got(ph=%0d dat=%0d) exp(ph=%0d dat=%0d)", s, p, o_ph[p], o_dat[p], p, e[p]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    in_data = '0;
    ram_clr = 1'b1;
    wp = 0;
    for (int i = 0; i < DEPTH; i++) ring[i] = '0;
    load_coefs(0);
    test_reset();
    test_single();
    test_ring_wrap();
    test_impulse();
    test_back_to_back();
    test_reset_mid();
    test_sload_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_mac_scheduler.md
FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

Interface
Parameters:
REQ-001 The block SHALL have parameter TAPS_PER_PHASE, default 8: taps per polyphase branch, 2..2^SAMP_AW.
REQ-002 The block SHALL have parameter NUM_PHASES, default 4: polyphase branches, 1..2^(COEF_AW)/TAPS_PER_PHASE.
REQ-003 The block SHALL have parameter SAMP_AW, default 3: sample-RAM address width, ring depth 2^SAMP_AW.
REQ-004 The block SHALL have parameter COEF_AW, default 5: coefficient-ROM address width.
REQ-005 The block SHALL have parameter WIDTH_OUT, default 40: MAC accumulator and output width.
Ports:
REQ-006 The block SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 The block SHALL have port in_valid, input, 1: new input sample present on the sample-RAM write data bus.
REQ-009 The block SHALL have port in_ready, output, 1: sample accepted when in_valid && in_ready.
REQ-010 The block SHALL have port samp_we, output, 1: sample-RAM write enable.
REQ-011 The block SHALL have port samp_wr_addr, output, SAMP_AW: sample-RAM write address (wr_ptr).
REQ-012 The block SHALL have port samp_rd_addr, output, SAMP_AW: sample-RAM read address; RAM read latency is 1 cycle.
REQ-013 The block SHALL have port coef_rd_addr, output, COEF_AW: coefficient-ROM read address; ROM read latency is 1 cycle.
REQ-014 The block SHALL have port mac_accum_sload, output, 1: drives the 3-stage MAC accum_sload input.
REQ-015 The block SHALL have port mac_result, input, WIDTH_OUT signed: MAC result output.
REQ-016 The block SHALL have port out_valid, output, 1: one-cycle pulse per computed phase output.
REQ-017 The block SHALL have port out_data, output, WIDTH_OUT signed: captured filter output.
REQ-018 The block SHALL have port out_phase, output, clog2(NUM_PHASES) (min 1): phase index of out_data.
REQ-019 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, WRITE, ISSUE, DRAIN, EMIT.
REQ-021 In IDLE, in_ready SHALL be 1; on in_valid, the block SHALL assert samp_we for one cycle at samp_wr_addr=wr_ptr and go to WRITE.
REQ-022 In WRITE, the block SHALL increment wr_ptr mod 2^SAMP_AW, set phase=0 and k=0, and go to ISSUE; in_ready SHALL be 0 in all states except IDLE.
REQ-023 In ISSUE, one tap SHALL be issued per cycle for k=0..TAPS_PER_PHASE-1, with coef_rd_addr=phase*TAPS_PER_PHASE+k and samp_rd_addr=(wr_ptr-1-k) mod 2^SAMP_AW; the newest sample is tap 0 and the ring wraps.
REQ-024 mac_accum_sload SHALL be 1 for exactly one cycle: the second cycle after tap 0 is issued (ISSUE cycle c2, or the matching DRAIN cycle if TAPS_PER_PHASE=2); it SHALL be 0 at all other times.
REQ-025 After tap TAPS_PER_PHASE-1 is issued (cycle c(T-1)), the block SHALL enter DRAIN for 3 cycles, covering RAM latency plus the 2 MAC stages between the operand and sload registers and the result register.
REQ-026 The block SHALL then enter EMIT (cycle c(T+3)), set out_data<=mac_result and out_phase<=phase, and pulse out_valid the following cycle; end-to-end latency from tap-0 issue to out_valid is T+4 cycles.
REQ-027 After EMIT, if phase<NUM_PHASES-1, the block SHALL increment phase, set k=0, and go to ISSUE; otherwise it SHALL go to IDLE.
REQ-028 Each accepted sample SHALL produce exactly NUM_PHASES outputs with phases 0..NUM_PHASES-1 in order.
REQ-029 in_valid while busy SHALL be ignored; no write occurs and no sample is lost silently, since the upstream must hold in_valid.
REQ-030 out_data SHALL hold its value between out_valid pulses.
REQ-031 The block SHALL perform no arithmetic on samples; wr_ptr, k and phase counters SHALL wrap modulo their widths only as specified.

Reset
REQ-032 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, wr_ptr=0, phase=0, k=0, out_data=0, out_phase=0, out_valid=0, samp_we=0, mac_accum_sload=0, samp_rd_addr=0, coef_rd_addr=0 and busy=0, with in_ready=1 from the first cycle after release.
REQ-033 Reset mid-burst SHALL abort the burst with no out_valid; any stale MAC content SHALL be discarded by the next mac_accum_sload.

Verification
REQ-034 The bench SHALL cover: reset then a single in_valid with T=8, P=4 -> samp_we at addr 0; outputs at phases 0,1,2,3; out_valid every 12 cycles; the first out_valid 14 cycles after acceptance.
REQ-035 The bench SHALL cover: coefficients all 1 and samples 1..9 written -> the 9th-sample outputs equal 9+8+...+2=44 for every phase, confirming ring wrap at depth 8.
REQ-036 The bench SHALL cover: impulse (one sample=1, rest 0) with coef=index -> successive samples' phase-p outputs walk p*8+0 .. p*8+7.
REQ-037 The bench SHALL cover: in_valid held high continuously -> in_ready=1 only in IDLE; exactly one write per 4-output burst; no duplicate outputs.
REQ-038 The bench SHALL cover: rst_n=0 during ISSUE of phase 2 -> no further out_valid; the next sample writes at addr 0 and restarts at phase 0 with a correct sum.
REQ-039 The bench SHALL cover: monitoring mac_accum_sload -> exactly NUM_PHASES pulses per sample, each at the second cycle after tap-0 issue.
